// File: rtl/ecg_sample_feeder.sv
// ecg_sample_feeder: buffers one window of ECG samples and feeds it to the
// ECG CNN core, then holds the core's detection result for downstream.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   wr_valid/wr_ready/wr_data     upstream sample stream
//   wr_last                       marks the final sample of a window
//   core_start                    one-cycle start pulse to the core
//   core_state                    core FSM state (1/3/4 request input)
//   core_xin                      sample to the core, same-cycle as request
//   core_done/core_result         core completion and detection_out
//   res_valid/res_ready/res_data  result handshake and captured result
//   res_count                     buffered samples consumed by the core
//   res_timeout                   run ended by timeout instead of done
//   busy                          high in START, STREAM and RESULT
module ecg_sample_feeder #(
    parameter int unsigned N       = 16,
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned AW      = 8,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic signed [N-1:0] wr_data,
    input  logic                wr_last,
    output logic                core_start,
    input  logic [3:0]          core_state,
    output logic signed [N-1:0] core_xin,
    input  logic                core_done,
    input  logic signed [N-1:0] core_result,
    output logic                res_valid,
    input  logic                res_ready,
    output logic signed [N-1:0] res_data,
    output logic [AW-1:0]       res_count,
    output logic                res_timeout,
    output logic                busy
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_START  = 2'd1,
        S_STREAM = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic signed [N-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_cnt;
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       len;
    logic [TW-1:0]       to_cnt;

    logic wr_fire;
    logic last_in;
    logic consume;
    logic have_sample;
    logic to_hit;

    // Shared decodes used by both the FSM and the datapath
    always_comb begin
        wr_fire     = wr_valid & wr_ready;
        last_in     = wr_last | (wr_cnt == AW'(DEPTH - 1));
        consume     = (state_q == S_STREAM) &&
                      ((core_state == 4'd1) || (core_state == 4'd3) || (core_state == 4'd4));
        have_sample = (rd_ptr < len);
        to_hit      = (to_cnt == TW'(TIMEOUT - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:   if (wr_fire && last_in) state_d = S_START;
            S_START:  state_d = S_STREAM;
            S_STREAM: if (core_done || to_hit) state_d = S_RESULT;
            S_RESULT: if (res_ready) state_d = S_LOAD;
            default:  state_d = S_LOAD;
        endcase
    end

    // Outputs decoded from state; core_xin follows core_state with no latency
    always_comb begin
        wr_ready   = 1'b0;
        core_start = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b0;
        core_xin   = '0;
        case (state_q)
            S_LOAD:   wr_ready = (wr_cnt < AW'(DEPTH));
            S_START: begin
                core_start = 1'b1;
                busy       = 1'b1;
            end
            S_STREAM: busy = 1'b1;
            S_RESULT: begin
                res_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
        if (consume && have_sample) begin
            core_xin = mem[rd_ptr[IW-1:0]];
        end
    end

    // Sample buffer; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (!rst && wr_fire) begin
            mem[wr_cnt[IW-1:0]] <= wr_data;
        end
    end

    // Counters and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt      <= '0;
            rd_ptr      <= '0;
            len         <= '0;
            to_cnt      <= '0;
            res_data    <= '0;
            res_count   <= '0;
            res_timeout <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (wr_fire) begin
                        wr_cnt <= wr_cnt + AW'(1);
                        if (last_in) begin
                            len <= wr_cnt + AW'(1);
                        end
                    end
                end
                S_START: begin
                    rd_ptr <= '0;
                    to_cnt <= '0;
                end
                S_STREAM: begin
                    to_cnt <= to_cnt + TW'(1);
                    // done wins over an advance in the same cycle
                    if (core_done) begin
                        res_data    <= core_result;
                        res_count   <= rd_ptr;
                        res_timeout <= 1'b0;
                    end else if (to_hit) begin
                        res_data    <= '0;
                        res_count   <= rd_ptr;
                        res_timeout <= 1'b1;
                    end else if (consume && have_sample) begin
                        rd_ptr <= rd_ptr + AW'(1);
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        wr_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ecg_sample_feeder.sv
// Bench for ecg_sample_feeder: directed windows plus randomized core behaviour,
// checked against a window/queue model of the expected sample feed.
module tb_ecg_sample_feeder;

    localparam int N       = 16;
    localparam int DEPTH   = 128;
    localparam int AW      = 8;
    localparam int TIMEOUT = 4096;

    logic                clk = 1'b0;
    logic                rst;
    logic                wr_valid;
    logic                wr_ready;
    logic signed [N-1:0] wr_data;
    logic                wr_last;
    logic                core_start;
    logic [3:0]          core_state;
    logic signed [N-1:0] core_xin;
    logic                core_done;
    logic signed [N-1:0] core_result;
    logic                res_valid;
    logic                res_ready;
    logic signed [N-1:0] res_data;
    logic [AW-1:0]       res_count;
    logic                res_timeout;
    logic                busy;

    ecg_sample_feeder #(.N(N), .DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
        .core_start(core_start), .core_state(core_state), .core_xin(core_xin),
        .core_done(core_done), .core_result(core_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_count(res_count), .res_timeout(res_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Model: current window contents and expected result of the run
    int win[$];
    int wlen;
    int exp_data;
    int exp_cnt;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] pick_cons();
        int t = $urandom_range(0, 2);
        return (t == 0) ? 4'd1 : (t == 1) ? 4'd3 : 4'd4;
    endfunction

    function automatic logic [3:0] pick_idle(input int mode);
        int t = $urandom_range(0, 12);
        if (mode == 1) return 4'd2;
        return (t == 0) ? 4'd0 : (t == 1) ? 4'd2 : 4'(t + 3);
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, "_wr_ready"}, wr_ready, 1);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_core_xin"}, core_xin, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_count"}, res_count, 0);
        chk({tag, "_res_timeout"}, res_timeout, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Push win[0..wlen-1]; idle beats carry a stray wr_last that must be ignored
    task automatic load_window(input bit use_last, input bit extra_beat);
        for (int i = 0; i < wlen; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                wr_valid = 1'b0;
                wr_last  = 1'($urandom_range(0, 1));
                #1;
                chk("wr_ready_idle", wr_ready, 1);
                cyc();
            end
            wr_valid = 1'b1;
            wr_data  = 16'(win[i]);
            wr_last  = use_last && (i == wlen - 1);
            #1;
            chk("wr_ready_load", wr_ready, 1);
            cyc();
        end
        wr_valid = extra_beat;
        wr_data  = 16'sd1234;
        wr_last  = 1'b0;
        #1;
        chk("start_pulse", core_start, 1);
        chk("wr_ready_start", wr_ready, 0);
        chk("busy_start", busy, 1);
        cyc();
        wr_valid = 1'b0;
    endtask

    // Drive n_cons consume cycles (mode 0 dense, 1 alternating 1/2, 2 random),
    // then a done cycle; every consume cycle k must present window entry k or 0.
    task automatic stream(input int n_cons, input int mode, input int result, input bit done_cons);
        int  k = 0;
        int  c = 0;
        bit  cons;
        int  ex;
        chk("start_single_pulse", core_start, 0);
        while (k < n_cons && c < 3000) begin
            case (mode)
                0:       cons = 1'b1;
                1:       cons = (c % 2 == 0);
                default: cons = ($urandom_range(0, 2) != 0);
            endcase
            core_state = cons ? pick_cons() : pick_idle(mode);
            core_done  = 1'b0;
            #1;
            ex = (cons && k < wlen) ? win[k] : 0;
            chk("xin", core_xin, ex);
            if (cons) k++;
            c++;
            cyc();
        end
        chk("stream_bound", k, n_cons);
        core_state  = done_cons ? pick_cons() : 4'd0;
        core_done   = 1'b1;
        core_result = 16'(result);
        #1;
        ex = (done_cons && k < wlen) ? win[k] : 0;
        chk("xin_done_cycle", core_xin, ex);
        cyc();
        core_done  = 1'b0;
        core_state = 4'd0;
        exp_data = result;
        exp_cnt  = (k < wlen) ? k : wlen;
        #1;
        chk("res_valid", res_valid, 1);
        chk("res_data", res_data, exp_data);
        chk("res_count", res_count, exp_cnt);
        chk("res_timeout", res_timeout, 0);
    endtask

    // Hold the result under backpressure (stray done must be ignored), then accept
    task automatic result_hs(input int hold, input bit exp_to);
        for (int i = 0; i < hold; i++) begin
            res_ready   = 1'b0;
            core_done   = 1'($urandom_range(0, 1));
            core_result = 16'sh7777;
            #1;
            chk("hold_res_valid", res_valid, 1);
            chk("hold_res_data", res_data, exp_data);
            chk("hold_res_count", res_count, exp_cnt);
            chk("hold_res_timeout", res_timeout, exp_to);
            chk("hold_wr_ready", wr_ready, 0);
            cyc();
        end
        core_done = 1'b0;
        res_ready = 1'b1;
        #1;
        chk("accept_res_valid", res_valid, 1);
        cyc();
        res_ready = 1'b0;
        #1;
        chk("after_accept_wr_ready", wr_ready, 1);
        chk("after_accept_res_valid", res_valid, 0);
        chk("after_accept_busy", busy, 0);
    endtask

    task automatic rand_window(input int n);
        win.delete();
        for (int i = 0; i < n; i++) win.push_back(int'($urandom_range(0, 65535)) - 32768);
        wlen = n;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired: observed=no_finish expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
        core_state = 4'd0; core_done = 1'b0; core_result = '0; res_ready = 1'b0;
        cyc();
        check_reset_state("reset");
        cyc();
        rst = 1'b0;

        // Ramp window, 80 consume cycles, result held 10 cycles
        win.delete();
        for (int i = 0; i < 66; i++) win.push_back(i * 10);
        wlen = 66;
        load_window(1'b1, 1'b0);
        stream(80, 0, 37, 1'b0);
        result_hs(10, 1'b0);

        // Descending second window right after the handshake
        win.delete();
        for (int i = 0; i < 66; i++) win.push_back(660 - 10 * i);
        wlen = 66;
        load_window(1'b1, 1'b0);
        stream(70, 2, 123, 1'b0);
        result_hs(2, 1'b0);

        // Consume gaps: state alternates 1/2
        rand_window(20);
        load_window(1'b1, 1'b0);
        stream(25, 1, -5, 1'b0);
        result_hs(1, 1'b0);

        // Full buffer without wr_last; a 129th beat is offered during START
        rand_window(DEPTH);
        load_window(1'b0, 1'b1);
        stream(DEPTH + 2, 2, 100, 1'b0);
        result_hs(3, 1'b0);

        // Timeout: three samples consumed, done never raised
        rand_window(5);
        load_window(1'b1, 1'b0);
        for (int c = 0; c < TIMEOUT - 1; c++) begin
            core_state = (c < 3) ? 4'd1 : 4'd0;
            if (c < 3) begin
                #1;
                chk("to_xin", core_xin, win[c]);
            end
            cyc();
        end
        core_state = 4'd0;
        chk("to_not_yet", res_valid, 0);
        cyc();
        exp_data = 0;
        exp_cnt  = 3;
        chk("to_res_valid", res_valid, 1);
        chk("to_res_timeout", res_timeout, 1);
        chk("to_res_data", res_data, 0);
        chk("to_res_count", res_count, 3);
        result_hs(2, 1'b1);

        // Reset mid-STREAM after 20 samples consumed
        rand_window(30);
        load_window(1'b1, 1'b0);
        for (int c = 0; c < 20; c++) begin
            core_state = pick_cons();
            #1;
            chk("pre_rst_xin", core_xin, win[c]);
            cyc();
        end
        core_state = 4'd0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_reset_state("mid_rst");

        // done on a consume cycle: that cycle is not counted
        rand_window(10);
        load_window(1'b1, 1'b0);
        stream(5, 0, 77, 1'b1);
        result_hs(1, 1'b0);

        // Single-sample window boundary
        rand_window(1);
        load_window(1'b1, 1'b0);
        stream(3, 2, -1, 1'b1);
        result_hs(0, 1'b0);

        // Randomized windows
        for (int t = 0; t < 5; t++) begin
            rand_window($urandom_range(1, 40));
            load_window(1'b1, 1'b0);
            stream(wlen + $urandom_range(0, 8) - $urandom_range(0, 3), 2,
                   int'($urandom_range(0, 65535)) - 32768, 1'($urandom_range(0, 1)));
            result_hs($urandom_range(0, 4), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ecg_sample_feeder.md
# ecg_sample_feeder

Sample-side partner of the ECG CNN core (`ECG_Top`). It buffers one window of ECG samples from an upstream valid/ready stream and issues the single-cycle `start` pulse to the core. It then supplies one sample on `xin` in every cycle the core's state requests input, zero-padding once the window is exhausted. When the core raises `done`, it captures `detection_out` and presents it downstream through a valid/ready result port.

## Interface
Parameters:
- `N`, 16, sample and result width (matches the core's `N`)
- `DEPTH`, 128, maximum samples per window
- `AW`, 8, pointer/count width; must satisfy 2^AW > DEPTH
- `TIMEOUT`, 4096, STREAM cycles allowed before abandoning a run

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `wr_valid` in 1: upstream sample valid.
- `wr_ready` out 1: feeder can accept a sample.
- `wr_data` in N (signed): ECG sample.
- `wr_last` in 1: qualifies the final sample of the window.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_state` in 4: core FSM state.
- `core_xin` out N (signed): sample to the core.
- `core_done` in 1: core finished.
- `core_result` in N (signed): core `detection_out`.
- `res_valid` out 1: result held for downstream.
- `res_ready` in 1: downstream accepts the result.
- `res_data` out N (signed): captured detection result.
- `res_count` out AW: number of buffered samples consumed by the core.
- `res_timeout` out 1: run ended by timeout, not by `done`.
- `busy` out 1: high in START, STREAM and RESULT.

## Operation
The feeder is an FSM with four states: LOAD, START, STREAM and RESULT. Reset enters LOAD with `wr_cnt`, `rd_ptr`, `len` and the timeout counter cleared. Buffer contents are not reset.

- **LOAD**
  - `wr_ready` = (`wr_cnt` < `DEPTH`).
  - On each `wr_valid & wr_ready`: write `buf[wr_cnt]`, then increment `wr_cnt`.
  - If the accepted sample has `wr_last`, or `wr_cnt` becomes `DEPTH`: latch `len` = `wr_cnt`+1 and go to START.
  - A window therefore always holds 1..`DEPTH` samples. `wr_last` on any non-accepted cycle is ignored.
- **START**
  - `core_start` = 1 for exactly this one cycle.
  - Clear `rd_ptr` and the timeout counter, then go to STREAM.
- **STREAM**
  - Consume cycle: `core_state` ∈ {1, 3, 4}.
  - `core_xin` (combinational) = `buf[rd_ptr]` if this is a consume cycle and `rd_ptr` < `len`; otherwise 0.
  - At posedge of a consume cycle with `core_done` = 0 and `rd_ptr` < `len`: increment `rd_ptr`.
  - Non-consume cycles (e.g. `core_state` 0, 2, 5+) do not advance `rd_ptr`.
  - `core_done` = 1: capture `res_data` = `core_result`, `res_count` = `rd_ptr`, `res_timeout` = 0, then go to RESULT. `done` takes priority over an advance in the same cycle; `core_xin` is still driven that cycle.
  - Timeout counter increments every STREAM cycle. When it reaches `TIMEOUT`-1 with no `done`: `res_data` = 0, `res_count` = `rd_ptr`, `res_timeout` = 1, go to RESULT.
- **RESULT**
  - `res_valid` = 1; `res_data`, `res_count` and `res_timeout` stay stable.
  - On `res_ready`: clear `wr_cnt` and go to LOAD.
- `wr_ready` = 0 in every state except LOAD.
- `core_done` outside STREAM is ignored.

## Timing
- Reset values (after the first posedge with `rst` = 1):
  - `wr_ready` = 1, since the FSM is in LOAD.
  - 0: `core_start`, `core_xin`, `res_valid`, `res_data`, `res_count`, `res_timeout`, `busy`.
- Last accepted sample at edge k: `core_start` = 1 in cycle k+1; STREAM begins at k+2.
- `core_xin` has zero latency relative to `core_state`. The sample is valid in the same cycle the core shows a consume state, and the core samples it at that posedge.
- Result: `core_done` high at edge d gives `res_valid` = 1 from cycle d+1. The result is held for any number of cycles while `res_ready` = 0.
- `res_valid & res_ready` at edge r gives `wr_ready` = 1 from cycle r+1. There is no bubble beyond that.
- `rst` mid-operation (any state): the next cycle is LOAD with all counters cleared and `res_valid` = 0. A partial window is discarded, and `core_start` is not re-issued.
- Widths:
  - `rd_ptr`, `wr_cnt` and `len` are AW bits and never wrap: `rd_ptr` saturates at `len`.
  - The timeout counter is `$clog2(TIMEOUT)`+1 bits.

## Test plan
- **Ramp window:** 66 samples `i*10` with `wr_last` on the 66th; the core model consumes in states 1/3/4 for 80 consume cycles, then raises `done` with `core_result` = 37.
  - `core_start` is one pulse.
  - `core_xin` = 0, 10, …, 650, then 0 ×14.
  - `res_data` = 37, `res_count` = 66, `res_timeout` = 0.
- **Consume gaps:** `core_state` alternates 1 and 2.
  - `core_xin` = 0 on state-2 cycles, and the sequence is not skipped or repeated.
- **Full buffer:** 128 samples without `wr_last`.
  - `wr_ready` drops after the 128th sample; `len` = 128.
  - A 129th `wr_valid` is not accepted.
- **Timeout:** the core never raises `done`.
  - After 4096 STREAM cycles: `res_valid` = 1, `res_timeout` = 1, `res_data` = 0.
- **Backpressure:** hold `res_ready` = 0 for 10 cycles.
  - `res_*` is stable and `wr_ready` = 0.
  - `res_ready` pulse → `wr_ready` = 1 next cycle.
  - A second window (a descending pattern, `660 - 10*i`) runs correctly.
- **Reset mid-STREAM and `done` collision:**
  - Assert `rst` at `rd_ptr` = 20: LOAD next cycle with outputs at reset values.
  - `done` coinciding with a consume cycle: `res_count` excludes that cycle.
